// File: rtl/adc_sample_averager.sv
// rtl/adc_sample_averager.sv - boxcar averager of ADC sequencer packets into a 5-channel snapshot
// Collects one sample per mapped slot per packet, averages 2^LOG2_AVG full packets, pulses avg_valid.
module adc_sample_averager #(
  parameter int         DATA_W   = 12,
  parameter int         LOG2_AVG = 3,
  parameter logic [4:0] CH_ID0   = 5'h01,
  parameter logic [4:0] CH_ID1   = 5'h02,
  parameter logic [4:0] CH_ID2   = 5'h03,
  parameter logic [4:0] CH_ID3   = 5'h04,
  parameter logic [4:0] CH_ID4   = 5'h06
) (
  input  logic              clk_core,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [4:0]        in_channel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_startofpacket,
  input  logic              in_endofpacket,
  input  logic              error_clear,
  output logic [DATA_W-1:0] avg_ch0,
  output logic [DATA_W-1:0] avg_ch1,
  output logic [DATA_W-1:0] avg_ch2,
  output logic [DATA_W-1:0] avg_ch3,
  output logic [DATA_W-1:0] avg_ch4,
  output logic              avg_valid,
  output logic [7:0]        drop_count,
  output logic              error_sticky
);

  localparam int AW     = DATA_W + LOG2_AVG;
  localparam int SW     = AW + 1;
  localparam int CW     = LOG2_AVG + 1;
  localparam int RND_SH = (LOG2_AVG > 0) ? LOG2_AVG - 1 : 0;
  localparam logic [SW-1:0] ROUND    = (LOG2_AVG > 0) ? SW'(1 << RND_SH) : '0;
  localparam logic [CW-1:0] SEQ_LAST = CW'((1 << LOG2_AVG) - 1);

  typedef enum logic {WAIT_SOP, COLLECT} state_t;

  state_t            r_state;
  logic [4:0]        r_seen;
  logic [DATA_W-1:0] r_stage  [5];
  logic [DATA_W-1:0] r_cstage [5];
  logic              r_commit_pend;
  logic [AW-1:0]     r_acc    [5];
  logic [CW-1:0]     r_seq_cnt;
  logic [DATA_W-1:0] r_avg    [5];
  logic              r_avg_valid;
  logic [7:0]        r_drop_count;
  logic              r_error;

  logic [4:0]        w_hit;
  logic [4:0]        w_base;
  logic [4:0]        w_wr;
  logic              w_beat;
  logic              w_accept;
  logic              w_orphan;
  logic              w_restart;
  logic              w_eop;
  logic              w_full;
  logic              w_commit;
  logic              w_err;
  logic [1:0]        w_drops;
  logic [8:0]        w_drop_sum;
  logic [DATA_W-1:0] w_stage_m [5];
  logic [SW-1:0]     w_sum     [5];
  logic              w_last;

  assign w_hit = {in_channel == CH_ID4, in_channel == CH_ID3, in_channel == CH_ID2,
                  in_channel == CH_ID1, in_channel == CH_ID0};

  always_comb begin
    w_beat     = in_valid & enable;
    w_accept   = w_beat & (in_startofpacket | (r_state == COLLECT));
    w_orphan   = w_beat & ~in_startofpacket & (r_state == WAIT_SOP);
    w_restart  = w_beat & in_startofpacket & (r_state == COLLECT);
    // A sop beat always opens a fresh packet, so it never sees an earlier slot as a duplicate
    w_base     = in_startofpacket ? 5'b0 : r_seen;
    w_wr       = w_hit & ~w_base & {5{w_accept}};
    w_eop      = w_accept & in_endofpacket;
    w_full     = (w_base | w_wr) == 5'h1f;
    w_commit   = w_eop & w_full;
    w_err      = w_orphan | w_restart | (w_accept & |(w_hit & w_base));
    w_drops    = 2'(w_restart) + 2'(w_eop & ~w_full);
    w_drop_sum = {1'b0, r_drop_count} + 9'(w_drops);
    w_last     = (r_seq_cnt == SEQ_LAST);
    for (int k = 0; k < 5; k++) begin
      w_stage_m[k] = w_wr[k] ? in_data : r_stage[k];
      w_sum[k]     = {1'b0, r_acc[k]} + SW'(r_cstage[k]) + ROUND;
    end
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_state       <= WAIT_SOP;
      r_seen        <= '0;
      r_commit_pend <= 1'b0;
      r_seq_cnt     <= '0;
      r_avg_valid   <= 1'b0;
      r_drop_count  <= '0;
      r_error       <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        r_stage[k]  <= '0;
        r_cstage[k] <= '0;
        r_acc[k]    <= '0;
        r_avg[k]    <= '0;
      end
    end else begin
      r_avg_valid <= 1'b0;
      if (!enable) begin
        r_state       <= WAIT_SOP;
        r_seen        <= '0;
        r_commit_pend <= 1'b0;
        r_seq_cnt     <= '0;
        for (int k = 0; k < 5; k++) r_acc[k] <= '0;
      end else begin
        if (w_accept) begin
          r_seen  <= w_base | w_wr;
          r_state <= w_eop ? WAIT_SOP : COLLECT;
        end
        for (int k = 0; k < 5; k++) begin
          if (w_wr[k]) r_stage[k] <= in_data;
        end
        // Commit snapshot lets the next packet overwrite r_stage while the commit is in flight
        r_commit_pend <= w_commit;
        if (w_commit) begin
          for (int k = 0; k < 5; k++) r_cstage[k] <= w_stage_m[k];
        end
        if (r_commit_pend) begin
          if (w_last) begin
            r_seq_cnt   <= '0;
            r_avg_valid <= 1'b1;
            for (int k = 0; k < 5; k++) begin
              r_avg[k] <= DATA_W'(w_sum[k] >> LOG2_AVG);
              r_acc[k] <= '0;
            end
          end else begin
            r_seq_cnt <= r_seq_cnt + 1'b1;
            for (int k = 0; k < 5; k++) r_acc[k] <= r_acc[k] + AW'(r_cstage[k]);
          end
        end
      end
      r_drop_count <= w_drop_sum[8] ? 8'hff : w_drop_sum[7:0];
      if (w_err)            r_error <= 1'b1;
      else if (error_clear) r_error <= 1'b0;
    end
  end

  assign avg_ch0      = r_avg[0];
  assign avg_ch1      = r_avg[1];
  assign avg_ch2      = r_avg[2];
  assign avg_ch3      = r_avg[3];
  assign avg_ch4      = r_avg[4];
  assign avg_valid    = r_avg_valid;
  assign drop_count   = r_drop_count;
  assign error_sticky = r_error;

endmodule

// File: tb/tb_adc_sample_averager.sv
// tb/tb_adc_sample_averager.sv - scoreboard bench for adc_sample_averager
module tb_adc_sample_averager;

  logic        clk_core = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [4:0]  in_channel;
  logic [11:0] in_data;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic        error_clear;
  logic [11:0] avg_ch0, avg_ch1, avg_ch2, avg_ch3, avg_ch4;
  logic        avg_valid;
  logic [7:0]  drop_count;
  logic        error_sticky;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_pulses = 0;
  int m_sum [5];
  int m_cnt = 0;
  int q_cyc [$];
  logic [59:0] q_val [$];

  adc_sample_averager dut (
    .clk_core(clk_core), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_channel(in_channel), .in_data(in_data), .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket), .error_clear(error_clear),
    .avg_ch0(avg_ch0), .avg_ch1(avg_ch1), .avg_ch2(avg_ch2), .avg_ch3(avg_ch3),
    .avg_ch4(avg_ch4), .avg_valid(avg_valid), .drop_count(drop_count),
    .error_sticky(error_sticky)
  );

  always #5 clk_core = ~clk_core;
  always @(posedge clk_core) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int ch_id(input int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 4;
      default: return 6;
    endcase
  endfunction

  function automatic int avg_slot(input int k);
    case (k)
      0: return int'(avg_ch0);
      1: return int'(avg_ch1);
      2: return int'(avg_ch2);
      3: return int'(avg_ch3);
      default: return int'(avg_ch4);
    endcase
  endfunction

  always @(negedge clk_core) begin
    if (avg_valid) begin
      n_pulses++;
      if (q_cyc.size() == 0) begin
        check_eq("unexpected_avg_valid", 1, 0);
      end else begin
        int ec;
        logic [59:0] ev;
        ec = q_cyc.pop_front();
        ev = q_val.pop_front();
        check_eq("avg_valid_latency", cyc, ec);
        for (int k = 0; k < 5; k++) check_eq($sformatf("avg_ch%0d", k), avg_slot(k), int'(ev[k*12 +: 12]));
      end
    end
  end

  task automatic model_clear();
    for (int k = 0; k < 5; k++) m_sum[k] = 0;
    m_cnt = 0;
  endtask

  task automatic model_commit(input int v [5], input int c0);
    logic [59:0] ev;
    for (int k = 0; k < 5; k++) m_sum[k] += v[k];
    m_cnt++;
    if (m_cnt == 8) begin
      for (int k = 0; k < 5; k++) ev[k*12 +: 12] = 12'((m_sum[k] + 4) >> 3);
      q_cyc.push_back(c0 + 2);
      q_val.push_back(ev);
      model_clear();
    end
  endtask

  task automatic beat(input int ch, input int d, input bit sop, input bit eop, output int c0);
    @(negedge clk_core);
    in_valid = 1'b1;
    in_channel = 5'(ch);
    in_data = 12'(d);
    in_startofpacket = sop;
    in_endofpacket = eop;
    error_clear = 1'b0;
    c0 = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_core);
      in_valid = 1'b0;
      in_startofpacket = 1'b0;
      in_endofpacket = 1'b0;
      error_clear = 1'b0;
    end
  endtask

  task automatic send_pkt(input int a, b, c, d, e, input logic [4:0] mask, input bit model_on);
    int v [5];
    int first, last, c0;
    v = '{a, b, c, d, e};
    first = -1;
    last = -1;
    for (int k = 0; k < 5; k++) if (mask[k]) begin
      if (first < 0) first = k;
      last = k;
    end
    for (int k = 0; k < 5; k++) if (mask[k]) beat(ch_id(k), v[k], k == first, k == last, c0);
    if (mask == 5'h1f && model_on) model_commit(v, c0);
  endtask

  task automatic check_avgs(input string tag, input int a, b, c, d, e);
    int v [5];
    v = '{a, b, c, d, e};
    for (int k = 0; k < 5; k++) check_eq($sformatf("%s_ch%0d", tag, k), avg_slot(k), v[k]);
  endtask

  initial begin
    int c0, p0, r;
    int v [5];
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_channel = '0; in_data = '0;
    in_startofpacket = 1'b0; in_endofpacket = 1'b0; error_clear = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_core);
    reset = 1'b0;
    check_avgs("reset", 0, 0, 0, 0, 0);
    check_eq("reset_valid", int'(avg_valid), 0);
    check_eq("reset_drop", int'(drop_count), 0);
    check_eq("reset_err", int'(error_sticky), 0);

    // Constant packets, back to back
    p0 = n_pulses;
    repeat (8) send_pkt(100, 200, 300, 400, 500, 5'h1f, 1'b1);
    idle(5);
    check_eq("t1_pulses", n_pulses - p0, 1);
    check_avgs("t1", 100, 200, 300, 400, 500);
    check_eq("t1_drop", int'(drop_count), 0);

    for (int i = 0; i < 8; i++) send_pkt(i, 1000, 1000, 1000, 1000, 5'h1f, 1'b1);
    idle(4);
    check_avgs("t2_ramp", 4, 1000, 1000, 1000, 1000);
    repeat (8) send_pkt(4095, 4095, 4095, 4095, 4095, 5'h1f, 1'b1);
    idle(4);
    check_avgs("t2_max", 4095, 4095, 4095, 4095, 4095);

    // Incomplete packet is dropped and does not count toward the average
    send_pkt(9, 9, 9, 9, 9, 5'h0f, 1'b1);
    idle(2);
    check_eq("t3_drop", int'(drop_count), 1);
    p0 = n_pulses;
    repeat (8) send_pkt(50, 50, 50, 50, 50, 5'h1f, 1'b1);
    idle(4);
    check_eq("t3_pulses", n_pulses - p0, 1);
    check_avgs("t3", 50, 50, 50, 50, 50);

    // Protocol errors
    beat(2, 7, 1'b0, 1'b0, c0);
    idle(2);
    check_eq("t4_orphan_err", int'(error_sticky), 1);
    check_eq("t4_orphan_drop", int'(drop_count), 1);
    @(negedge clk_core); error_clear = 1'b1;
    idle(1);
    check_eq("t4_clear", int'(error_sticky), 0);
    beat(1, 20, 1'b1, 1'b0, c0);
    beat(2, 30, 1'b0, 1'b0, c0);
    beat(2, 999, 1'b0, 1'b0, c0);
    beat(3, 40, 1'b0, 1'b0, c0);
    beat(4, 50, 1'b0, 1'b0, c0);
    beat(6, 60, 1'b0, 1'b1, c0);
    v = '{20, 30, 40, 50, 60};
    model_commit(v, c0);
    idle(2);
    check_eq("t4_dup_err", int'(error_sticky), 1);
    check_eq("t4_dup_drop", int'(drop_count), 1);
    @(negedge clk_core); error_clear = 1'b1;
    idle(1);
    beat(1, 1, 1'b1, 1'b0, c0);
    beat(2, 2, 1'b0, 1'b0, c0);
    send_pkt(21, 31, 41, 51, 61, 5'h1f, 1'b1);
    idle(2);
    check_eq("t4_restart_err", int'(error_sticky), 1);
    check_eq("t4_restart_drop", int'(drop_count), 2);
    @(negedge clk_core); error_clear = 1'b1;
    idle(1);
    beat(3, 5, 1'b0, 1'b0, c0);
    error_clear = 1'b1;
    idle(2);
    check_eq("t4_set_wins", int'(error_sticky), 1);
    @(negedge clk_core); error_clear = 1'b1;
    idle(1);
    check_eq("t4_clear2", int'(error_sticky), 0);

    // Enable drop mid-accumulation discards everything gathered so far
    repeat (5) send_pkt(10, 20, 30, 40, 50, 5'h1f, 1'b0);
    beat(1, 11, 1'b1, 1'b0, c0);
    beat(2, 22, 1'b0, 1'b0, c0);
    @(negedge clk_core); in_valid = 1'b0; enable = 1'b0;
    model_clear();
    send_pkt(1, 2, 3, 4, 5, 5'h1f, 1'b0);
    beat(3, 5, 1'b0, 1'b0, c0);
    idle(3);
    check_avgs("t5_hold", 50, 50, 50, 50, 50);
    check_eq("t5_drop", int'(drop_count), 2);
    check_eq("t5_err", int'(error_sticky), 0);
    @(negedge clk_core); enable = 1'b1;
    p0 = n_pulses;
    repeat (8) send_pkt(7, 8, 9, 10, 11, 5'h1f, 1'b1);
    idle(4);
    check_eq("t5_pulses", n_pulses - p0, 1);
    check_avgs("t5", 7, 8, 9, 10, 11);

    // Reset in the commit cycle of the 8th packet
    p0 = n_pulses;
    repeat (8) send_pkt(300, 300, 300, 300, 300, 5'h1f, 1'b1);
    @(negedge clk_core); in_valid = 1'b0; reset = 1'b1;
    q_cyc.delete(); q_val.delete(); model_clear();
    @(negedge clk_core); reset = 1'b0;
    idle(3);
    check_eq("t6_pulses", n_pulses - p0, 0);
    check_avgs("t6_rst", 0, 0, 0, 0, 0);
    check_eq("t6_drop", int'(drop_count), 0);
    check_eq("t6_err", int'(error_sticky), 0);
    p0 = n_pulses;
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 4095);
      send_pkt(r, 4095 - r, i * 100, 123, $urandom_range(0, 4095), 5'h1f, 1'b1);
    end
    idle(5);
    check_eq("t6_pulses2", n_pulses - p0, 1);
    check_eq("queue_empty", q_cyc.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1);
  end

endmodule
